// File: rtl/doppler_iq_demod.sv
// Range-gated fs/4 quadrature demodulator. It skips GATE_DELAY ADC samples per receive window,
// then accumulates GATE_LEN samples into signed I/Q sums.
module doppler_iq_demod #(
  parameter int unsigned ADCBITS    = 14,
  parameter int unsigned ACCBITS    = 24,
  parameter int unsigned GATE_DELAY = 16,
  parameter int unsigned GATE_LEN   = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rxEnable,
  input  logic               adcReady,
  input  logic [ADCBITS-1:0] adcIn,
  output logic [ACCBITS-1:0] iOut,
  output logic [ACCBITS-1:0] qOut,
  output logic               iqValid,
  output logic               busy
);

  localparam int unsigned CNTW = 16;
  localparam logic [CNTW-1:0] DLY_LAST = CNTW'((GATE_DELAY == 0) ? 0 : GATE_DELAY - 1);
  localparam logic [CNTW-1:0] LEN_LAST = CNTW'(GATE_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_ACCUM, S_DONE} state_e;

  state_e               state_q, state_d;
  logic                 rdy_q, rx_q;
  logic                 samp_vld_q;
  logic [ADCBITS-1:0]   samp_q;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [1:0]           ph_q, ph_d;
  logic [ACCBITS-1:0]   acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [ACCBITS-1:0]   iout_q, qout_q;
  logic                 iqvalid_q, busy_q;
  logic [ACCBITS-1:0]   x_ext;
  logic                 qual;

  assign qual  = adcReady & ~rdy_q;
  assign x_ext = {{(ACCBITS-ADCBITS){samp_q[ADCBITS-1]}}, samp_q};

  // Samples are qualified and sign-converted here, so the FSM consumes them one edge later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rdy_q      <= 1'b0;
      rx_q       <= 1'b0;
      samp_vld_q <= 1'b0;
      samp_q     <= '0;
      cnt_q      <= '0;
      ph_q       <= '0;
      acc_i_q    <= '0;
      acc_q_q    <= '0;
      iout_q     <= '0;
      qout_q     <= '0;
      iqvalid_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= adcReady;
      rx_q       <= rxEnable;
      samp_vld_q <= qual;
      if (qual) samp_q <= {~adcIn[ADCBITS-1], adcIn[ADCBITS-2:0]};
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      acc_i_q    <= acc_i_d;
      acc_q_q    <= acc_q_d;
      iqvalid_q  <= (state_q == S_DONE);
      busy_q     <= (state_q == S_DELAY) || (state_q == S_ACCUM);
      if (state_q == S_DONE) begin
        iout_q <= acc_i_q;
        qout_q <= acc_q_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        ph_d    = '0;
        acc_i_d = '0;
        acc_q_d = '0;
        if (rxEnable && !rx_q) state_d = (GATE_DELAY == 0) ? S_ACCUM : S_DELAY;
      end
      S_DELAY: begin
        if (!rxEnable) begin
          state_d = S_IDLE;
        end else if (samp_vld_q) begin
          if (cnt_q == DLY_LAST) begin
            state_d = S_ACCUM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      S_ACCUM: begin
        if (!rxEnable) begin
          state_d = S_IDLE;
        end else if (samp_vld_q) begin
          // Mixing with the fs/4 reference +1, 0, -1, 0 reduces to alternating add/subtract on I and Q.
          unique case (ph_q)
            2'd0:    acc_i_d = acc_i_q + x_ext;
            2'd1:    acc_q_d = acc_q_q + x_ext;
            2'd2:    acc_i_d = acc_i_q - x_ext;
            default: acc_q_d = acc_q_q - x_ext;
          endcase
          ph_d = ph_q + 2'd1;
          if (cnt_q == LEN_LAST) state_d = S_DONE;
          else                   cnt_d   = cnt_q + CNTW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign iOut    = iout_q;
  assign qOut    = qout_q;
  assign iqValid = iqvalid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_doppler_iq_demod.sv
// Directed bench for doppler_iq_demod using the default parameters (delay 16, length 64).
// Expected I/Q sums are hand-computed.
module tb_doppler_iq_demod;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rxEnable;
  logic        adcReady;
  logic [13:0] adcIn;
  logic [23:0] iOut, qOut;
  logic        iqValid, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int qual_cyc = 0;
  int valid_cyc = 0;
  int valid_cnt = 0;

  doppler_iq_demod dut (
    .clk(clk), .rst_n(rst_n), .rxEnable(rxEnable), .adcReady(adcReady), .adcIn(adcIn),
    .iOut(iOut), .qOut(qOut), .iqValid(iqValid), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (iqValid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0d (0x%h) expected=%0d (0x%h)", tag, obs, obs, exp, exp);
    end
  endtask

  // One sample: adcReady held high 5 clk, low 3 clk; records the qualifying edge.
  task automatic feed(input logic [13:0] v);
    adcIn    = v;
    adcReady = 1'b1;
    @(posedge clk); #1;
    qual_cyc = cyc;
    repeat (4) @(posedge clk);
    #1 adcReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_window(input string tag, input logic [13:0] p0, input logic [13:0] p1,
                            input logic [13:0] p2, input logic [13:0] p3,
                            input logic [23:0] ei, input logic [23:0] eq, input bit glitch);
    int n0;
    n0 = valid_cnt;
    rxEnable = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      feed(14'h3FFF);
      if (i == 0) check({tag, "_busy"}, 24'(busy), 24'd1);
      if (glitch && i == 4) begin
        #2 rxEnable = 1'b0;
        #3 rxEnable = 1'b1;
      end
    end
    for (int g = 0; g < 16; g++) begin
      feed(p0); feed(p1); feed(p2); feed(p3);
    end
    for (int t = 0; t < 20 && valid_cnt == n0; t++) @(posedge clk);
    #1;
    check({tag, "_nvalid"}, 24'(valid_cnt - n0), 24'd1);
    check({tag, "_latency"}, 24'(valid_cyc - qual_cyc), 24'd2);
    check({tag, "_i"}, iOut, ei);
    check({tag, "_q"}, qOut, eq);
    rxEnable = 1'b0;
    @(posedge clk); #1;
    check({tag, "_busy_off"}, 24'(busy), 24'd0);
  endtask

  initial begin
    int n0;
    rst_n    = 1'b0;
    rxEnable = 1'b0;
    adcReady = 1'b0;
    adcIn    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_i", iOut, 24'd0);
    check("rst_q", qOut, 24'd0);
    check("rst_valid", 24'(iqValid), 24'd0);
    check("rst_busy", 24'(busy), 24'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_window("dc",  14'd12000, 14'd12000, 14'd12000, 14'd12000, 24'd0, 24'd0, 1'b0);
    run_window("cos", 14'd9192, 14'd8192, 14'd7192, 14'd8192, 24'd32000, 24'd0, 1'b0);
    run_window("sin", 14'd8192, 14'd9192, 14'd8192, 14'd7192, 24'd0, 24'd32000, 1'b0);

    // Abort after 40 accumulated samples: outputs must hold the sine result.
    n0 = valid_cnt;
    rxEnable = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) feed(14'h3FFF);
    for (int g = 0; g < 10; g++) begin
      feed(14'd9192); feed(14'd8192); feed(14'd7192); feed(14'd8192);
    end
    rxEnable = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_nvalid", 24'(valid_cnt - n0), 24'd0);
    check("abort_i", iOut, 24'd0);
    check("abort_q", qOut, 24'd32000);
    check("abort_busy", 24'(busy), 24'd0);

    // x = +1500, +500, -500, -500  ->  I = 16*2000, Q = 16*1000
    run_window("offs", 14'd9692, 14'd8692, 14'd7692, 14'd7692, 24'd32000, 24'd16000, 1'b0);
    // Negative cosine with an unsampled rxEnable glitch mid-window
    run_window("negcos", 14'd7192, 14'd8192, 14'd9192, 14'd8192, 24'(-32000), 24'd0, 1'b1);

    // Reset in the middle of ACCUM.
    n0 = valid_cnt;
    rxEnable = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) feed(14'h3FFF);
    for (int i = 0; i < 10; i++) feed(14'd9000);
    rst_n    = 1'b0;
    rxEnable = 1'b0;
    @(posedge clk); #1;
    check("midrst_i", iOut, 24'd0);
    check("midrst_q", qOut, 24'd0);
    check("midrst_valid", 24'(iqValid), 24'd0);
    check("midrst_busy", 24'(busy), 24'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) feed(14'd9000);
    repeat (10) @(posedge clk);
    #1;
    check("midrst_nvalid", 24'(valid_cnt - n0), 24'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
